// File: rtl/udt_pkg.sv
// Shared types and helpers for the UDT receive-side classifier.
package udt_pkg;

  // Control-type field value (tdata[62:48] of a control packet) for handshakes.
  localparam logic [14:0] CTRL_TYPE_HANDSHAKE = 15'h0;

  // Default handshake length in 64-bit beats (16 B header + 48 B body).
  localparam int HS_BEATS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    PASS_DATA,
    PASS_CTRL,
    HS_CAP,
    HS_EMIT,
    DROP
  } state_e;

  typedef enum logic [1:0] {
    DATA,
    HS,
    CTRL
  } pkt_class_e;

  // Classify a packet from the top 16 bits of its first beat:
  // bit 63 is the control flag, bits 62:48 the control type.
  function automatic pkt_class_e classify(input logic [15:0] hdr);
    pkt_class_e c;
    if (!hdr[15]) begin
      c = DATA;
    end else if (hdr[14:0] == CTRL_TYPE_HANDSHAKE) begin
      c = HS;
    end else begin
      c = CTRL;
    end
    return c;
  endfunction

endpackage

// File: rtl/udt_hs_buf.sv
// Whole-packet handshake buffer: HS_BEATS x 64-bit registers with a write
// pointer that doubles as the captured beat count and an independent read
// pointer used during replay.
module udt_hs_buf #(
  parameter int HS_BEATS = 8,
  parameter int PTR_W    = $clog2(HS_BEATS),
  parameter int BC_W     = $clog2(HS_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [63:0]      wr_data_i,
  input  logic             rd_adv_i,
  output logic [63:0]      rd_data_o,
  output logic             rd_last_o,
  output logic [BC_W-1:0]  beat_cnt_o
);

  localparam logic [BC_W-1:0]  BC_ONE    = {{(BC_W-1){1'b0}}, 1'b1};
  localparam logic [BC_W-1:0]  BC_FULL   = BC_W'(HS_BEATS);
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_FINAL = PTR_W'(HS_BEATS - 1);

  logic [63:0]      mem_q [HS_BEATS];
  logic [BC_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_ok_s;

  // Writes beyond the buffer depth are ignored; the FSM drops such packets.
  assign wr_ok_s = wr_en_i && (wr_cnt_q < BC_FULL);

  // Pointer next-state: clear has priority over write/advance.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_cnt_d = {BC_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_cnt_d = wr_cnt_q + BC_ONE;
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
      if (rd_adv_i) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_cnt_q <= {BC_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Beat storage; contents are only meaningful below the write pointer.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !clr_i) begin
      mem_q[wr_cnt_q[PTR_W-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign rd_last_o  = (rd_ptr_q == PTR_FINAL);
  assign beat_cnt_o = wr_cnt_q;

endmodule

// File: rtl/udt_rx_classifier.sv
// UDT receive classifier: routes data and non-handshake control packets
// straight through, and buffers/validates handshake packets before
// replaying them to the listen block.
module udt_rx_classifier
  import udt_pkg::*;
#(
  parameter int HS_BEATS = HS_BEATS_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             core_rst,
  input  logic             listen_en,
  input  logic [63:0]      s_tdata,
  input  logic [7:0]       s_tkeep,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic [63:0]      handshake_tdata,
  output logic [7:0]       handshake_tkeep,
  output logic             handshake_tvalid,
  input  logic             handshake_tready,
  output logic             handshake_tlast,
  output logic [63:0]      ctrl_tdata,
  output logic [7:0]       ctrl_tkeep,
  output logic             ctrl_tvalid,
  output logic             ctrl_tlast,
  input  logic             ctrl_tready,
  output logic [63:0]      data_tdata,
  output logic [7:0]       data_tkeep,
  output logic             data_tvalid,
  output logic             data_tlast,
  input  logic             data_tready,
  output logic [CNT_W-1:0] hs_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int               PTR_W   = $clog2(HS_BEATS);
  localparam int               BC_W    = $clog2(HS_BEATS + 1);
  localparam logic [BC_W-1:0]  BC_ONE  = {{(BC_W-1){1'b0}}, 1'b1};
  localparam logic [BC_W-1:0]  BC_FULL = BC_W'(HS_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating statistics increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hs_cnt_q, hs_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             keep_ok_q, keep_ok_d;

  pkt_class_e       cls_s;
  logic             hs_capture_s;
  logic [BC_W-1:0]  beat_num_s;
  logic             keep_now_s;
  logic             hs_drop_s;

  logic             buf_wr_s, buf_clr_s, buf_rd_adv_s;
  logic [63:0]      buf_rd_data_s;
  logic             buf_rd_last_s;
  logic [BC_W-1:0]  buf_cnt_s;

  udt_hs_buf #(
    .HS_BEATS (HS_BEATS),
    .PTR_W    (PTR_W),
    .BC_W     (BC_W)
  ) u_hs_buf (
    .clk        (clk),
    .rst_i      (core_rst),
    .clr_i      (buf_clr_s),
    .wr_en_i    (buf_wr_s),
    .wr_data_i  (s_tdata),
    .rd_adv_i   (buf_rd_adv_s),
    .rd_data_o  (buf_rd_data_s),
    .rd_last_o  (buf_rd_last_s),
    .beat_cnt_o (buf_cnt_s)
  );

  // Only the first beat of a packet (seen in IDLE) is classified.
  assign cls_s        = classify(s_tdata[63:48]);
  assign hs_capture_s = (state_q == HS_CAP) || ((state_q == IDLE) && (cls_s == HS));
  // 1-based index of the beat currently offered to the capture logic.
  assign beat_num_s   = (state_q == IDLE) ? BC_ONE : (buf_cnt_s + BC_ONE);
  // Every captured beat must carry all eight bytes.
  assign keep_now_s   = ((state_q == IDLE) ? 1'b1 : keep_ok_q) && (s_tkeep == 8'hFF);

  // Pass-through ports mirror the inbound stream; only tvalid is steered.
  assign data_tdata      = s_tdata;
  assign data_tkeep      = s_tkeep;
  assign data_tlast      = s_tlast;
  assign ctrl_tdata      = s_tdata;
  assign ctrl_tkeep      = s_tkeep;
  assign ctrl_tlast      = s_tlast;
  assign handshake_tdata = buf_rd_data_s;
  assign handshake_tkeep = 8'hFF;
  assign hs_cnt          = hs_cnt_q;
  assign drop_cnt        = drop_cnt_q;

  // Next-state, routing and handshake capture/replay control.
  always_comb begin
    state_d          = state_q;
    hs_cnt_d         = hs_cnt_q;
    drop_cnt_d       = drop_cnt_q;
    keep_ok_d        = keep_ok_q;
    s_tready         = 1'b0;
    data_tvalid      = 1'b0;
    ctrl_tvalid      = 1'b0;
    handshake_tvalid = 1'b0;
    handshake_tlast  = 1'b0;
    buf_wr_s         = 1'b0;
    buf_clr_s        = 1'b0;
    buf_rd_adv_s     = 1'b0;
    hs_drop_s        = 1'b0;

    case (state_q)
      IDLE: begin
        case (cls_s)
          DATA: begin
            s_tready    = data_tready;
            data_tvalid = s_tvalid;
            if (s_tvalid && data_tready && !s_tlast) begin
              state_d = PASS_DATA;
            end else begin
              state_d = IDLE;
            end
          end
          CTRL: begin
            s_tready    = ctrl_tready;
            ctrl_tvalid = s_tvalid;
            if (s_tvalid && ctrl_tready && !s_tlast) begin
              state_d = PASS_CTRL;
            end else begin
              state_d = IDLE;
            end
          end
          HS: begin
            s_tready = 1'b1;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
      PASS_DATA: begin
        s_tready    = data_tready;
        data_tvalid = s_tvalid;
        if (s_tvalid && data_tready && s_tlast) begin
          state_d = IDLE;
        end else begin
          state_d = PASS_DATA;
        end
      end
      PASS_CTRL: begin
        s_tready    = ctrl_tready;
        ctrl_tvalid = s_tvalid;
        if (s_tvalid && ctrl_tready && s_tlast) begin
          state_d = IDLE;
        end else begin
          state_d = PASS_CTRL;
        end
      end
      HS_CAP: begin
        s_tready = 1'b1;
      end
      DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          hs_drop_s = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      HS_EMIT: begin
        handshake_tvalid = 1'b1;
        handshake_tlast  = buf_rd_last_s;
        if (handshake_tready) begin
          if (buf_rd_last_s) begin
            hs_cnt_d  = sat_inc(hs_cnt_q);
            buf_clr_s = 1'b1;
            state_d   = IDLE;
          end else begin
            buf_rd_adv_s = 1'b1;
          end
        end else begin
          state_d = HS_EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake capture, shared by the first beat (IDLE) and later beats.
    if (hs_capture_s && s_tvalid) begin
      buf_wr_s  = 1'b1;
      keep_ok_d = keep_now_s;
      if (s_tlast) begin
        if ((beat_num_s == BC_FULL) && keep_now_s && listen_en) begin
          state_d = HS_EMIT;
        end else begin
          hs_drop_s = 1'b1;
          state_d   = IDLE;
        end
      end else if (beat_num_s == BC_FULL) begin
        state_d = DROP;
      end else begin
        state_d = HS_CAP;
      end
    end else begin
      keep_ok_d = keep_ok_q;
    end

    // A rejected handshake is counted and its partial contents discarded.
    if (hs_drop_s) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
      buf_clr_s  = 1'b1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    // Nothing is accepted or offered while reset is held.
    if (core_rst) begin
      s_tready         = 1'b0;
      data_tvalid      = 1'b0;
      ctrl_tvalid      = 1'b0;
      handshake_tvalid = 1'b0;
      handshake_tlast  = 1'b0;
    end else begin
      buf_wr_s = buf_wr_s;
    end
  end

  // State and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (core_rst) begin
      state_q    <= IDLE;
      hs_cnt_q   <= {CNT_W{1'b0}};
      drop_cnt_q <= {CNT_W{1'b0}};
      keep_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hs_cnt_q   <= hs_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      keep_ok_q  <= keep_ok_d;
    end
  end

endmodule

// File: tb/tb_udt_rx_classifier.sv
// Directed testbench for udt_rx_classifier: a cycle-vector table for the
// pass-through paths plus hand-written handshake capture/replay sequences.
module tb_udt_rx_classifier;

  logic        clk = 1'b0;
  logic        core_rst;
  logic        listen_en;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [63:0] handshake_tdata;
  logic [7:0]  handshake_tkeep;
  logic        handshake_tvalid;
  logic        handshake_tready;
  logic        handshake_tlast;
  logic [63:0] ctrl_tdata;
  logic [7:0]  ctrl_tkeep;
  logic        ctrl_tvalid;
  logic        ctrl_tlast;
  logic        ctrl_tready;
  logic [63:0] data_tdata;
  logic [7:0]  data_tkeep;
  logic        data_tvalid;
  logic        data_tlast;
  logic        data_tready;
  logic [15:0] hs_cnt;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_beats [8];

  always #5 clk = ~clk;

  udt_rx_classifier #(.HS_BEATS(8), .CNT_W(16)) dut (
    .clk              (clk),
    .core_rst         (core_rst),
    .listen_en        (listen_en),
    .s_tdata          (s_tdata),
    .s_tkeep          (s_tkeep),
    .s_tvalid         (s_tvalid),
    .s_tready         (s_tready),
    .s_tlast          (s_tlast),
    .handshake_tdata  (handshake_tdata),
    .handshake_tkeep  (handshake_tkeep),
    .handshake_tvalid (handshake_tvalid),
    .handshake_tready (handshake_tready),
    .handshake_tlast  (handshake_tlast),
    .ctrl_tdata       (ctrl_tdata),
    .ctrl_tkeep       (ctrl_tkeep),
    .ctrl_tvalid      (ctrl_tvalid),
    .ctrl_tlast       (ctrl_tlast),
    .ctrl_tready      (ctrl_tready),
    .data_tdata       (data_tdata),
    .data_tkeep       (data_tkeep),
    .data_tvalid      (data_tvalid),
    .data_tlast       (data_tlast),
    .data_tready      (data_tready),
    .hs_cnt           (hs_cnt),
    .drop_cnt         (drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Sends an n-beat packet with a handshake first beat; one idle gap after beat 2.
  task automatic send_hs(input int n, input logic [7:0] last_keep, input logic [31:0] tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = (i == 0) ? 64'h8000_0000_0000_0000 : {tag, 32'(i)};
      s_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
      s_tlast  = (i == n - 1);
      if (i < 8) exp_beats[i] = s_tdata;
      #2;
      chk("hs_cap_s_tready", {63'd0, s_tready}, 64'd1);
      chk("hs_cap_no_hs_valid", {63'd0, handshake_tvalid}, 64'd0);
      if (i == 2) begin
        @(negedge clk);
        s_tvalid = 1'b0;
        #2;
        chk("hs_gap_s_tready", {63'd0, s_tready}, 64'd1);
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tkeep  = 8'hFF;
  endtask

  // Drains one 8-beat handshake; handshake_tready held low for 'stall' cycles.
  // Called at negedge+2 of the cycle after the inbound tlast.
  task automatic recv_hs(input int stall);
    int got = 0;
    int cyc = 0;
    while (got < 8 && cyc < 100) begin
      chk("hs_tvalid", {63'd0, handshake_tvalid}, 64'd1);
      chk("hs_tdata", handshake_tdata, exp_beats[got]);
      chk("hs_tlast", {63'd0, handshake_tlast}, {63'd0, (got == 7)});
      chk("hs_tkeep", {56'd0, handshake_tkeep}, 64'hFF);
      chk("emit_s_tready", {63'd0, s_tready}, 64'd0);
      handshake_tready = (cyc >= stall);
      if (handshake_tready) got++;
      @(negedge clk);
      #2;
      cyc++;
    end
    if (got < 8) begin
      n_cmp++;
      n_bad++;
      $display("FAIL hs_recv_timeout: got %0d beats, expected 8", got);
    end
    handshake_tready = 1'b0;
    chk("hs_tvalid_after", {63'd0, handshake_tvalid}, 64'd0);
  endtask

  typedef struct {
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        d_rdy;
    logic        c_rdy;
    logic        e_srdy;
    logic        e_dv;
    logic        e_cv;
  } vec_t;

  vec_t vt [13];

  initial begin
    // tdata, tvalid, tlast, data_tready, ctrl_tready | s_tready, data_tvalid, ctrl_tvalid
    vt[0]  = '{64'h0000_0005_1111_2222, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{64'h0000_0005_3333_4444, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{64'hFFFF_0000_5555_6666, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{64'h8002_0000_0000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{64'h8002_0000_0000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{64'h0000_0000_AAAA_BBBB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{64'h0000_0000_AAAA_BBBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{64'h8002_1234_0000_0009, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{64'h0000_0000_0000_0042, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[10] = '{64'h0000_0000_0000_0042, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[11] = '{64'h8001_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[12] = '{64'hC000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    core_rst = 1'b1; listen_en = 1'b1;
    s_tdata = 64'd0; s_tkeep = 8'hFF; s_tvalid = 1'b0; s_tlast = 1'b0;
    handshake_tready = 1'b0; ctrl_tready = 1'b1; data_tready = 1'b1;

    // Reset: nothing accepted or offered, even with a beat presented.
    repeat (2) @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 64'h0000_0000_0000_0001; s_tlast = 1'b1;
    #2;
    chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_data_tvalid", {63'd0, data_tvalid}, 64'd0);
    @(negedge clk);
    core_rst = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    #2;
    chk("rst_hs_cnt", {48'd0, hs_cnt}, 64'd0);
    chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    chk("rst_hs_tvalid", {63'd0, handshake_tvalid}, 64'd0);

    // Data / ctrl pass-through vector table.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      s_tdata = vt[i].tdata; s_tvalid = vt[i].tvalid; s_tlast = vt[i].tlast;
      s_tkeep = 8'hFF; data_tready = vt[i].d_rdy; ctrl_tready = vt[i].c_rdy;
      #2;
      chk($sformatf("vec%0d_s_tready", i), {63'd0, s_tready}, {63'd0, vt[i].e_srdy});
      chk($sformatf("vec%0d_data_tvalid", i), {63'd0, data_tvalid}, {63'd0, vt[i].e_dv});
      chk($sformatf("vec%0d_ctrl_tvalid", i), {63'd0, ctrl_tvalid}, {63'd0, vt[i].e_cv});
      chk($sformatf("vec%0d_hs_tvalid", i), {63'd0, handshake_tvalid}, 64'd0);
      if (vt[i].e_dv) chk($sformatf("vec%0d_data_tdata", i), data_tdata, vt[i].tdata);
      if (vt[i].e_cv) chk($sformatf("vec%0d_ctrl_tlast", i), {63'd0, ctrl_tlast}, {63'd0, vt[i].tlast});
    end
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; data_tready = 1'b1; ctrl_tready = 1'b1;

    // Valid 8-beat handshake, replayed starting one cycle after inbound tlast.
    send_hs(8, 8'hFF, 32'hA000_0000);
    #2;
    recv_hs(0);
    chk("hs1_hs_cnt", {48'd0, hs_cnt}, 64'd1);

    // Short (6) and long (10) handshakes are dropped without any emission.
    send_hs(6, 8'hFF, 32'hB000_0000);
    #2;
    chk("short_hs_tvalid", {63'd0, handshake_tvalid}, 64'd0);
    chk("short_drop_cnt", {48'd0, drop_cnt}, 64'd1);
    send_hs(10, 8'hFF, 32'hB100_0000);
    #2;
    chk("long_hs_tvalid", {63'd0, handshake_tvalid}, 64'd0);
    chk("long_drop_cnt", {48'd0, drop_cnt}, 64'd2);
    // Right length but partial keep on the final beat is malformed too.
    send_hs(8, 8'hF0, 32'hB200_0000);
    #2;
    chk("keep_hs_tvalid", {63'd0, handshake_tvalid}, 64'd0);
    chk("keep_drop_cnt", {48'd0, drop_cnt}, 64'd3);
    send_hs(8, 8'hFF, 32'hC000_0000);
    #2;
    recv_hs(0);
    chk("hs2_hs_cnt", {48'd0, hs_cnt}, 64'd2);

    // listen_en=0 drops an otherwise good handshake.
    listen_en = 1'b0;
    send_hs(8, 8'hFF, 32'hD000_0000);
    #2;
    chk("nolisten_hs_tvalid", {63'd0, handshake_tvalid}, 64'd0);
    chk("nolisten_drop_cnt", {48'd0, drop_cnt}, 64'd4);
    chk("nolisten_hs_cnt", {48'd0, hs_cnt}, 64'd2);
    listen_en = 1'b1;

    // Good handshake with a 5-cycle stall; a data beat waits behind it.
    send_hs(8, 8'hFF, 32'hE000_0000);
    #2;
    s_tdata = 64'h0000_0000_0000_00AB; s_tvalid = 1'b1; s_tlast = 1'b1; data_tready = 1'b1;
    recv_hs(5);
    chk("stall_hs_cnt", {48'd0, hs_cnt}, 64'd3);
    chk("post_emit_s_tready", {63'd0, s_tready}, 64'd1);
    chk("post_emit_data_tvalid", {63'd0, data_tvalid}, 64'd1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;

    // Reset during beat 4 of a handshake.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tkeep = 8'hFF; s_tlast = 1'b0;
      s_tdata = (i == 0) ? 64'h8000_0000_0000_0000 : {32'hF000_0000, 32'(i)};
    end
    @(negedge clk);
    core_rst = 1'b1; s_tdata = 64'hF000_0000_0000_0004;
    #2;
    chk("midrst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("midrst_hs_tvalid", {63'd0, handshake_tvalid}, 64'd0);
    chk("midrst_data_tvalid", {63'd0, data_tvalid}, 64'd0);
    chk("midrst_ctrl_tvalid", {63'd0, ctrl_tvalid}, 64'd0);
    @(negedge clk);
    core_rst = 1'b0;
    s_tdata = 64'h0000_0000_0000_0077; s_tvalid = 1'b1; s_tlast = 1'b1; data_tready = 1'b1;
    #2;
    chk("postrst_hs_cnt", {48'd0, hs_cnt}, 64'd0);
    chk("postrst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    chk("postrst_data_tvalid", {63'd0, data_tvalid}, 64'd1);
    chk("postrst_s_tready", {63'd0, s_tready}, 64'd1);
    chk("postrst_hs_tvalid", {63'd0, handshake_tvalid}, 64'd0);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #2;
    chk("postrst_idle_hs_tvalid", {63'd0, handshake_tvalid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
